// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial IF/MEM memory controller.
package mem_ctrl_pkg;

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic ENABLE = 1'b1;
  localparam logic STOP   = 1'b0;

  // Byte count for a size code; the reserved code 3 behaves as a word.
  function automatic logic [CNT_W-1:0] size_to_len(input logic [1:0] size);
    case (size)
      SIZE_B:  size_to_len = CNT_W'(1);
      SIZE_H:  size_to_len = CNT_W'(2);
      SIZE_W:  size_to_len = CNT_W'(4);
      default: size_to_len = CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the fetch port and the load/store port onto a byte-wide synchronous RAM,
// serialising little-endian 1/2/4-byte accesses one byte per cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic              stallreq_from_mem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, len, len_nxt, cnt_inc;
  logic [ADDR_W-1:0]  base, base_nxt, ram_addr_nxt;
  logic               owner_mem, owner_mem_nxt;
  logic [DATA_W-1:0]  wdata, wdata_nxt, rbuf, rbuf_nxt, rbuf_cap;
  logic [DATA_W-1:0]  if_data_nxt, mem_rdata_nxt;
  logic               if_done_nxt, mem_done_nxt, ram_wr_nxt;
  logic [BYTE_W-1:0]  ram_dout_nxt;
  logic               last_read, last_write;
  logic [1:0]         rd_lane, wr_lane;
  logic               unused_addr_bits;

  assign cnt_inc    = cnt + CNT_W'(1);
  assign last_read  = (cnt == len);
  assign last_write = (cnt_inc == len);
  // Read data for address i arrives one cycle later, so cycle cnt fills lane cnt-1.
  assign rd_lane    = 2'(cnt - CNT_W'(1));
  assign wr_lane    = 2'(cnt_inc);

  assign stallreq_from_mem = mem_req && !mem_done;
  assign unused_addr_bits  = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      len       <= '0;
      base      <= '0;
      owner_mem <= 1'b0;
      wdata     <= '0;
      rbuf      <= '0;
      if_data   <= '0;
      if_done   <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      len       <= len_nxt;
      base      <= base_nxt;
      owner_mem <= owner_mem_nxt;
      wdata     <= wdata_nxt;
      rbuf      <= rbuf_nxt;
      if_data   <= if_data_nxt;
      if_done   <= if_done_nxt;
      mem_rdata <= mem_rdata_nxt;
      mem_done  <= mem_done_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_wr    <= ram_wr_nxt;
      ram_dout  <= ram_dout_nxt;
    end
  end

  // Next state; MEM wins in IDLE and a running fetch is never preempted.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mem_req)     state_nxt = mem_we ? ST_WRITE : ST_READ;
        else if (if_req) state_nxt = ST_READ;
      end
      ST_READ:  if (last_read)  state_nxt = ST_DONE;
      ST_WRITE: if (last_write) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    cnt_nxt       = cnt;
    len_nxt       = len;
    base_nxt      = base;
    owner_mem_nxt = owner_mem;
    wdata_nxt     = wdata;
    rbuf_nxt      = rbuf;
    if_data_nxt   = if_data;
    mem_rdata_nxt = mem_rdata;
    if_done_nxt   = STOP;
    mem_done_nxt  = STOP;
    ram_wr_nxt    = STOP;
    ram_addr_nxt  = ram_addr;
    ram_dout_nxt  = ram_dout;
    rbuf_cap      = rbuf;
    rbuf_cap[{rd_lane, 3'b000} +: BYTE_W] = ram_din;

    case (state)
      ST_IDLE: begin
        if (mem_req || if_req) begin
          owner_mem_nxt = mem_req;
          base_nxt      = mem_req ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
          len_nxt       = mem_req ? size_to_len(mem_size) : CNT_W'(4);
          wdata_nxt     = mem_wdata;
          rbuf_nxt      = '0;
          cnt_nxt       = '0;
          ram_addr_nxt  = base_nxt;
          if (mem_req && mem_we) begin
            ram_wr_nxt   = ENABLE;
            ram_dout_nxt = mem_wdata[BYTE_W-1:0];
          end
        end
      end
      ST_READ: begin
        cnt_nxt = cnt_inc;
        if (cnt != '0) rbuf_nxt = rbuf_cap;
        if (cnt_inc < len) ram_addr_nxt = base + ADDR_W'(cnt_inc);
        if (last_read) begin
          if (owner_mem) begin
            mem_rdata_nxt = rbuf_cap;
            mem_done_nxt  = ENABLE;
          end else begin
            if_data_nxt = rbuf_cap;
            if_done_nxt = ENABLE;
          end
        end
      end
      ST_WRITE: begin
        if (last_write) begin
          cnt_nxt      = '0;
          mem_done_nxt = ENABLE;
        end else begin
          cnt_nxt      = cnt_inc;
          ram_wr_nxt   = ENABLE;
          ram_addr_nxt = base + ADDR_W'(cnt_inc);
          ram_dout_nxt = wdata[{wr_lane, 3'b000} +: BYTE_W];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic
// against a byte-array memory model.
module tb_mem_ctrl;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned RAM_SZ = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              stallreq_from_mem;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  int checks = 0;
  int errors = 0;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stallreq_from_mem(stallreq_from_mem),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM with a bench-side poke port and one-shot pattern fill.
  logic [7:0]        ram [RAM_SZ];
  logic [7:0]        model_mem [RAM_SZ];
  logic              ram_ready = 1'b0;
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_addr = '0;
  logic [7:0]        poke_data = '0;

  function automatic logic [7:0] pat(input int unsigned i);
    return 8'((i * 32'd157) ^ (i >> 7) ^ 32'h5A);
  endfunction

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < RAM_SZ; i++) ram[i] <= pat(i);
      ram_ready <= 1'b1;
    end else if (poke_en) ram[poke_addr] <= poke_data;
    else if (ram_wr) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  // Per-cycle trace of the most recent run_txn, index = cycle after request.
  logic [ADDR_W-1:0] tr_addr [40];
  logic              tr_wr   [40];
  logic [7:0]        tr_dout [40];
  logic              tr_stall[40];

  function automatic int len_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (32'(model_mem[ADDR_W'(addr + 32'(i))]) << (8 * i));
    return v;
  endfunction

  task automatic model_write(input logic [31:0] addr, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) model_mem[ADDR_W'(addr + 32'(i))] = 8'(wd >> (8 * i));
  endtask

  task automatic poke(input logic [31:0] addr, input logic [7:0] d);
    poke_addr = ADDR_W'(addr);
    poke_data = d;
    poke_en   = 1'b1;
    model_mem[ADDR_W'(addr)] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Issue one request from IDLE, record the trace, drop req the cycle after done.
  task automatic run_txn(input bit is_mem, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] data, output int other_done);
    lat = -1;
    data = '0;
    other_done = 0;
    if (is_mem) begin
      mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wd; mem_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    #1;
    tr_addr[0] = ram_addr; tr_wr[0] = ram_wr; tr_dout[0] = ram_dout; tr_stall[0] = stallreq_from_mem;
    for (int k = 1; k < 40; k++) begin
      @(posedge clk); #1;
      tr_addr[k] = ram_addr; tr_wr[k] = ram_wr; tr_dout[k] = ram_dout; tr_stall[k] = stallreq_from_mem;
      if (is_mem ? if_done : mem_done) other_done++;
      if (is_mem ? mem_done : if_done) begin
        lat = k;
        data = is_mem ? mem_rdata : if_data;
        break;
      end
    end
    @(posedge clk); #1;
    mem_req = 1'b0;
    if_req  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    mem_size = 2'd0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({if_done, mem_done, ram_wr, stallreq_from_mem} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {if_done, mem_done, ram_wr, stallreq_from_mem});
    end
    checks++;
    if (ram_addr !== '0 || ram_dout !== 8'h00) begin
      errors++; $display("FAIL reset_ram_bus: got addr %h dout %h expected 0/0", ram_addr, ram_dout);
    end
    checks++;
    if (if_data !== 32'h0 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got if_data %h mem_rdata %h expected 0/0", if_data, mem_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_basic;
    int lat, od, wr_cnt;
    logic [31:0] data;
    poke(32'h0, 8'h13); poke(32'h1, 8'h05); poke(32'h2, 8'h00); poke(32'h3, 8'h00);
    run_txn(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, lat, data, od);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL fetch_latency: got %0d expected 6", lat); end
    checks++;
    if (data !== 32'h0000_0513) begin errors++; $display("FAIL fetch_data: got %h expected 00000513", data); end
    wr_cnt = 0;
    for (int k = 0; k <= 6; k++) if (tr_wr[k] !== 1'b0) wr_cnt++;
    checks++;
    if (wr_cnt !== 0 || od !== 0) begin
      errors++; $display("FAIL fetch_side_effects: got wr_cycles %0d mem_done %0d expected 0/0", wr_cnt, od);
    end
  endtask

  task automatic test_store_word;
    int lat, od;
    logic [31:0] data, wd;
    logic [7:0] exp_b;
    wd = 32'hDEAD_BEEF;
    run_txn(1'b1, 1'b1, 2'd2, 32'h100, wd, lat, data, od);
    model_write(32'h100, 4, wd);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL store_latency: got %0d expected 5", lat); end
    for (int k = 1; k <= 4; k++) begin
      exp_b = 8'(wd >> (8 * (k - 1)));
      checks++;
      if (tr_wr[k] !== 1'b1 || tr_addr[k] !== ADDR_W'(32'h100 + 32'(k - 1)) || tr_dout[k] !== exp_b) begin
        errors++;
        $display("FAIL store_cycle%0d: got wr %b addr %h byte %h expected 1 %h %h",
                 k, tr_wr[k], tr_addr[k], tr_dout[k], ADDR_W'(32'h100 + 32'(k - 1)), exp_b);
      end
    end
    checks++;
    if (tr_wr[0] !== 1'b0 || tr_wr[5] !== 1'b0) begin
      errors++; $display("FAIL store_wr_edges: got cyc0 %b cyc5 %b expected 0/0", tr_wr[0], tr_wr[5]);
    end
    checks++;
    if ({tr_stall[0], tr_stall[1], tr_stall[2], tr_stall[3], tr_stall[4], tr_stall[5]} !== 6'b111110) begin
      errors++;
      $display("FAIL store_stall: got %b expected 111110",
               {tr_stall[0], tr_stall[1], tr_stall[2], tr_stall[3], tr_stall[4], tr_stall[5]});
    end
    checks++;
    if ({ram[ADDR_W'(32'h103)], ram[ADDR_W'(32'h102)], ram[ADDR_W'(32'h101)], ram[ADDR_W'(32'h100)]} !== wd) begin
      errors++; $display("FAIL store_ram_contents: got %h expected %h",
        {ram[ADDR_W'(32'h103)], ram[ADDR_W'(32'h102)], ram[ADDR_W'(32'h101)], ram[ADDR_W'(32'h100)]}, wd);
    end
  endtask

  task automatic test_simultaneous;
    int idone, mdone, both;
    logic [31:0] ird, mrd, exp_i, exp_m;
    exp_m = model_read(32'h100, 1);
    exp_i = model_read(32'h0, 4);
    idone = -1; mdone = -1; both = 0; ird = '0; mrd = '0;
    if_addr = 32'h0; if_req = 1'b1;
    mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h100; mem_req = 1'b1;
    for (int k = 1; k < 30; k++) begin
      @(posedge clk); #1;
      if (if_done && mem_done) both++;
      if (mem_done && mdone < 0) begin mdone = k; mrd = mem_rdata; end
      if (if_done && idone < 0) begin idone = k; ird = if_data; end
      if (mdone > 0 && k == mdone + 1) mem_req = 1'b0;
      if (idone > 0 && k == idone + 1) break;
    end
    if_req = 1'b0; mem_req = 1'b0;
    checks++;
    if (mdone !== 3 || mrd !== exp_m) begin
      errors++; $display("FAIL simul_mem: got done@%0d data %h expected done@3 data %h", mdone, mrd, exp_m);
    end
    checks++;
    if (idone !== 10 || ird !== exp_i) begin
      errors++; $display("FAIL simul_fetch: got done@%0d data %h expected done@10 data %h", idone, ird, exp_i);
    end
    checks++;
    if (both !== 0) begin errors++; $display("FAIL simul_both_done: got %0d expected 0", both); end
  endtask

  task automatic test_mem_during_fetch;
    int idone, mdone, wr_first, stall_err;
    logic [31:0] wd;
    wd = $urandom();
    idone = -1; mdone = -1; wr_first = -1; stall_err = 0;
    if_addr = 32'h0; if_req = 1'b1;
    for (int k = 1; k < 30; k++) begin
      @(posedge clk); #1;
      if (if_done && idone < 0) idone = k;
      if (mem_done && mdone < 0) mdone = k;
      if (ram_wr && wr_first < 0) wr_first = k;
      if (k == 2) begin
        mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h200; mem_wdata = wd; mem_req = 1'b1;
      end
      if (idone > 0 && k == idone + 1) if_req = 1'b0;
      if (mdone > 0 && k == mdone + 1) begin mem_req = 1'b0; break; end
      @(negedge clk);
      if (stallreq_from_mem !== (k >= 2 && k < 12)) stall_err++;
    end
    if_req = 1'b0; mem_req = 1'b0;
    model_write(32'h200, 4, wd);
    checks++;
    if (idone !== 6) begin errors++; $display("FAIL nopreempt_fetch_done: got %0d expected 6", idone); end
    checks++;
    if (wr_first !== 8 || mdone !== 12) begin
      errors++; $display("FAIL nopreempt_store: got first_wr %0d done %0d expected 8/12", wr_first, mdone);
    end
    checks++;
    if (stall_err !== 0) begin errors++; $display("FAIL nopreempt_stall: got %0d bad cycles expected 0", stall_err); end
  endtask

  task automatic test_reset_mid_store;
    int lat, od, spurious;
    logic [31:0] data, wd, exp, got_mem;
    wd = $urandom();
    poke(32'h303, ~wd[31:24]);
    mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h300; mem_wdata = wd; mem_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ram_wr !== 1'b0 || mem_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got ram_wr %b mem_done %b expected 0/0", ram_wr, mem_done);
    end
    rst = 1'b0;
    spurious = 0;
    repeat (4) begin @(posedge clk); #1; if (mem_done || if_done || ram_wr) spurious++; end
    checks++;
    if (spurious !== 0) begin errors++; $display("FAIL rstmid_idle: got %0d active cycles expected 0", spurious); end
    model_write(32'h300, 3, wd);
    exp = model_read(32'h300, 4);
    got_mem = {ram[ADDR_W'(32'h303)], ram[ADDR_W'(32'h302)], ram[ADDR_W'(32'h301)], ram[ADDR_W'(32'h300)]};
    checks++;
    if (got_mem !== exp) begin errors++; $display("FAIL rstmid_partial_bytes: got %h expected %h", got_mem, exp); end
    exp = model_read(32'h302, 2);
    run_txn(1'b1, 1'b0, 2'd1, 32'h302, 32'h0, lat, data, od);
    checks++;
    if (lat !== 4 || data !== exp) begin
      errors++; $display("FAIL rstmid_halfload: got lat %0d data %h expected 4 %h", lat, data, exp);
    end
  endtask

  task automatic test_wrap;
    int lat, od;
    logic [31:0] data;
    poke(32'h1FFFF, 8'hA5);
    poke(32'h0, 8'h3C);
    run_txn(1'b1, 1'b0, 2'd1, 32'h0001_FFFF, 32'h0, lat, data, od);
    checks++;
    if (tr_addr[1] !== 17'h1FFFF || tr_addr[2] !== 17'h00000) begin
      errors++; $display("FAIL wrap_addrs: got %h %h expected 1ffff 00000", tr_addr[1], tr_addr[2]);
    end
    checks++;
    if (lat !== 4 || data !== 32'h0000_3CA5) begin
      errors++; $display("FAIL wrap_data: got lat %0d data %h expected 4 00003ca5", lat, data);
    end
  endtask

  task automatic test_random;
    int lat, od, n, exp_lat, wr_cnt, stall_bad, seq_bad, op;
    logic [31:0] addr, wd, data, exp, low;
    logic [1:0] size;
    for (int it = 0; it < 60; it++) begin
      op   = $urandom_range(0, 2);
      size = 2'($urandom_range(0, 3));
      low  = ($urandom_range(0, 3) == 0) ? 32'h1FFFC + 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 15));
      addr = ($urandom() & 32'hFFFE_0000) | low;
      wd   = $urandom();
      n    = (op == 0) ? 4 : len_of(size);
      exp  = model_read(addr, n);
      exp_lat = (op == 2) ? n + 1 : n + 2;
      run_txn(op != 0, op == 2, size, addr, wd, lat, data, od);
      checks++;
      if (lat !== exp_lat) begin
        errors++; $display("FAIL rand%0d_latency: op %0d size %0d got %0d expected %0d", it, op, size, lat, exp_lat);
      end
      wr_cnt = 0; stall_bad = 0; seq_bad = 0;
      for (int k = 0; k <= exp_lat; k++) begin
        if (tr_wr[k] === 1'b1) wr_cnt++;
        if (tr_stall[k] !== ((op != 0) && (k < exp_lat))) stall_bad++;
      end
      if (op == 2) begin
        for (int k = 1; k <= n; k++)
          if (tr_addr[k] !== ADDR_W'(addr + 32'(k - 1)) || tr_dout[k] !== 8'(wd >> (8 * (k - 1)))) seq_bad++;
        model_write(addr, n, wd);
      end else begin
        checks++;
        if (data !== exp) begin
          errors++; $display("FAIL rand%0d_data: op %0d addr %h got %h expected %h", it, op, addr, data, exp);
        end
      end
      checks++;
      if (wr_cnt !== ((op == 2) ? n : 0) || seq_bad !== 0) begin
        errors++; $display("FAIL rand%0d_ram_bus: got wr_cycles %0d bad_bytes %0d expected %0d/0",
                           it, wr_cnt, seq_bad, (op == 2) ? n : 0);
      end
      checks++;
      if (stall_bad !== 0 || od !== 0) begin
        errors++; $display("FAIL rand%0d_stall_done: got stall_bad %0d other_done %0d expected 0/0", it, stall_bad, od);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_SZ; i++) model_mem[i] = pat(i);
    test_reset();
    test_fetch_basic();
    test_store_word();
    test_simultaneous();
    test_mem_during_fetch();
    test_reset_mid_store();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
